// File: rtl/spi_master_nibble_if.sv
// spi_master_nibble_if
//   Bundles the host handshake and the SPI pins of spi_master_nibble.
//   Host side : start, tx_data (request and nibble to send)
//               busy, done, rx_data (status and last received nibble)
//   SPI side  : sclk_out, mosi_out, ss_n_out (driven by the master)
//               miso_in (driven by the peripheral, asynchronous to clk)
//   Modports  : master -- the SPI master block
//               slave  -- everything around it (host logic plus SPI peripheral)
interface spi_master_nibble_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  miso_in;
    logic                  sclk_out;
    logic                  mosi_out;
    logic                  ss_n_out;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;

    modport master (
        input  start, tx_data, miso_in,
        output sclk_out, mosi_out, ss_n_out, busy, done, rx_data
    );

    modport slave (
        output start, tx_data, miso_in,
        input  sclk_out, mosi_out, ss_n_out, busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_nibble.sv
// spi_master_nibble
//   Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master moving one nibble each way
//   per SS frame. Frame layout in clk cycles, H = CLK_DIV, start accepted at 0:
//     SETUP 1..H, XFER 1+H..9H (four SCLK pulses), HOLD 1+9H..10H,
//     GAP 1+10H..11H (done and rx_data update on its first cycle).
//   Ports:
//     clk   - system clock
//     reset - synchronous, active-high
//     bus   - spi_master_nibble_if.master (handshake + SPI pins)
module spi_master_nibble #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_nibble_if.master bus
);
    localparam int              CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [1:0]      BIT_LAST = 2'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;        // clk cycles within the current half-period
    logic [1:0]            bit_cnt;    // SCLK pulse index inside XFER
    logic                  sclk_q;     // SCLK level during XFER
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [1:0]            miso_sync;
    logic                  cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETUP;
            SETUP:   if (cnt_last) state_nxt = XFER;
            // Leave XFER only at the end of the low half of the last pulse.
            XFER:    if (cnt_last && !sclk_q && bit_cnt == BIT_LAST) state_nxt = HOLD;
            HOLD:    if (cnt_last) state_nxt = GAP;
            GAP:     if (cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: counters, shift registers, MISO synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            sclk_q    <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rx_q      <= '0;
            miso_sync <= '0;
        end else begin
            miso_sync <= {miso_sync[0], bus.miso_in};

            if (state == IDLE || cnt_last) cnt <= '0;
            else                           cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    sclk_q  <= 1'b0;
                    bit_cnt <= '0;
                    if (bus.start) begin
                        tx_shift <= bus.tx_data;
                        rx_shift <= '0;
                    end
                end
                SETUP: if (cnt_last) sclk_q <= 1'b1;
                XFER: begin
                    // First cycle of a high half: capture MISO.
                    if (sclk_q && cnt == '0)
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso_sync[1]};
                    // First cycle of a low half: advance MOSI, except after the last pulse.
                    if (!sclk_q && cnt == '0 && bit_cnt != BIT_LAST)
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    if (cnt_last) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                        end else if (bit_cnt != BIT_LAST) begin
                            sclk_q  <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                // Publish so rx_data changes on the same cycle done pulses.
                HOLD: if (cnt_last) rx_q <= rx_shift;
                default: ;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        bus.ss_n_out = 1'b1;
        bus.sclk_out = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        case (state)
            IDLE:        bus.busy = 1'b0;
            SETUP, HOLD: bus.ss_n_out = 1'b0;
            XFER: begin
                bus.ss_n_out = 1'b0;
                bus.sclk_out = sclk_q;
            end
            GAP:         bus.done = (cnt == '0);
            default: ;
        endcase
        bus.mosi_out = tx_shift[DATA_WIDTH-1];
        bus.rx_data  = rx_q;
    end
endmodule

// File: tb/tb_spi_master_nibble.sv
module tb_spi_master_nibble;
    localparam int H            = 4;
    localparam int LOG_N        = 64;
    localparam int FRAME_BUDGET = 200;

    typedef struct {
        int         done_cnt;
        int         done_at;
        logic [3:0] rx_done;
        int         ss_low;
        int         sclk_high;
        int         mosi_ones;
        int         rises;
        int         period_bad;
        logic [3:0] mosi_bits;
        int         end_k;
        logic       end_ss;
        logic       end_sclk;
        logic [3:0] end_rx;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loop_en = 1'b0;
    logic miso_drv = 1'b0;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    spi_master_nibble_if #(.DATA_WIDTH(4)) bus ();

    spi_master_nibble #(.CLK_DIV(H), .DATA_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.miso_in = loop_en ? bus.mosi_out : miso_drv;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_t is the position of the current cycle inside a frame (1..11H),
    // or -1 while idle. Outputs are pure functions of that position.
    int         m_t = -1;
    int         cyc = 0;
    int         m_dones = 0;
    logic [3:0] m_tx = '0;
    logic [3:0] m_acc = '0;
    logic [3:0] m_rx = '0;
    logic       miso_log [LOG_N];

    function automatic logic exp_sclk(input int t);
        return (t >= 1 + H) && (t <= 8 * H) && ((((t - 1 - H) / H) % 2) == 0);
    endfunction

    function automatic logic is_rise(input int t);
        return (t >= 1 + H) && (t <= 1 + 7 * H) && (((t - 1 - H) % (2 * H)) == 0);
    endfunction

    function automatic logic exp_mosi(input int t, input logic [3:0] tx);
        int j;
        j = 3;
        if (t >= 1) begin
            j = 0;
            for (int k = 1; k <= 3; k++) if (t >= 2 + 2 * k * H) j++;
        end
        return tx[3 - j];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("ss_n_out", bus.ss_n_out, !(m_t >= 1 && m_t <= 10 * H));
            check("sclk_out", bus.sclk_out, exp_sclk(m_t));
            check("mosi_out", bus.mosi_out, exp_mosi(m_t, m_tx));
            check("busy",     bus.busy,     m_t >= 1);
            check("done",     bus.done,     m_t == 1 + 10 * H);
            check("rx_data",  bus.rx_data,  m_rx);
            if (m_t == 1 + 10 * H) m_dones++;
        end
        miso_log[cyc % LOG_N] = bus.miso_in;
        if (reset) begin
            m_t = -1; m_tx = '0; m_acc = '0; m_rx = '0;
        end else if (m_t < 0) begin
            if (bus.start) begin
                m_t = 1; m_tx = bus.tx_data; m_acc = '0;
            end
        end else begin
            // DUT sees MISO through two flops: the pin value from two cycles back.
            if (is_rise(m_t)) m_acc = {m_acc[2:0], miso_log[(cyc + LOG_N - 2) % LOG_N]};
            if (m_t == 10 * H) m_rx = m_acc;
            m_t = (m_t == 11 * H) ? -1 : m_t + 1;
        end
        cyc++;
    end

    // ---------------- directed frame driver / observer ----------------
    task automatic run_frame(input logic [3:0] tx, input int poke, input int rst_at, output obs_t o);
        int   k;
        int   last_rise;
        logic prev_sclk;
        o = '{default: 0};
        prev_sclk = 1'b0;
        last_rise = 0;
        @(posedge clk); #1; bus.start = 1'b1; bus.tx_data = tx;
        @(posedge clk); #1; bus.start = 1'b0;
        k = 1;
        while (k < FRAME_BUDGET) begin
            @(negedge clk);
            if (!bus.ss_n_out) o.ss_low = o.ss_low + 1;
            if (!bus.ss_n_out && bus.mosi_out) o.mosi_ones = o.mosi_ones + 1;
            if (bus.sclk_out) o.sclk_high = o.sclk_high + 1;
            if (bus.sclk_out && !prev_sclk) begin
                if (o.rises > 0 && k - last_rise != 2 * H) o.period_bad = o.period_bad + 1;
                o.rises = o.rises + 1;
                last_rise = k;
                o.mosi_bits = {o.mosi_bits[2:0], bus.mosi_out};
            end
            prev_sclk = bus.sclk_out;
            if (bus.done) begin
                o.done_cnt = o.done_cnt + 1;
                o.done_at = k;
                o.rx_done = bus.rx_data;
            end
            if (k > 1 && !bus.busy) break;
            @(posedge clk); #1;
            k++;
            reset = (k == rst_at);
            if (k == poke) begin
                bus.start = 1'b1; bus.tx_data = 4'h5;
            end else begin
                bus.start = 1'b0;
            end
        end
        o.end_k = k;
        o.end_ss = bus.ss_n_out;
        o.end_sclk = bus.sclk_out;
        o.end_rx = bus.rx_data;
        check("frame_bounded", k < FRAME_BUDGET, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t       o;
        int         k;
        int         dones;
        int         gap;
        logic [3:0] rxs [2];

        bus.start = 1'b0;
        bus.tx_data = '0;
        @(posedge clk); #1; chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Loopback 0xA: the headline timing numbers.
        loop_en = 1'b1;
        run_frame(4'hA, -1, -1, o);
        check("lb_a_done_cnt", o.done_cnt, 1);
        check("lb_a_done_at", o.done_at, 41);
        check("lb_a_rx", o.rx_done, 4'hA);
        check("lb_a_ss_low", o.ss_low, 40);
        check("lb_a_rises", o.rises, 4);
        check("lb_a_period", o.period_bad, 0);
        check("lb_a_sclk_high", o.sclk_high, 16);
        check("lb_a_mosi_bits", o.mosi_bits, 4'b1010);
        check("lb_a_busy_fall", o.end_k, 45);

        // Fixed MISO levels.
        loop_en = 1'b0; miso_drv = 1'b1;
        run_frame(4'h0, -1, -1, o);
        check("fix1_rx", o.rx_done, 4'hF);
        check("fix1_mosi_ones", o.mosi_ones, 0);
        miso_drv = 1'b0;
        run_frame(4'hF, -1, -1, o);
        check("fix0_rx", o.rx_done, 4'h0);

        // Leave non-zero state behind, then reset while idle.
        loop_en = 1'b1;
        run_frame(4'h7, -1, -1, o);
        check("lb_7_rx", o.rx_done, 4'h7);
        @(posedge clk); #1; reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_ss", bus.ss_n_out, 1);
        check("rst_sclk", bus.sclk_out, 0);
        check("rst_mosi", bus.mosi_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rx", bus.rx_data, 4'h0);
        @(posedge clk); #1; reset = 1'b0;

        // Start pulsed while busy is ignored.
        run_frame(4'hC, 15, -1, o);
        check("poke_done_cnt", o.done_cnt, 1);
        check("poke_rx", o.rx_done, 4'hC);
        check("poke_busy_fall", o.end_k, 45);

        // Reset on the 3rd rising SCLK cycle.
        run_frame(4'hB, -1, 1 + 5 * H, o);
        check("abort_end", o.end_k, 2 + 5 * H);
        check("abort_done_cnt", o.done_cnt, 0);
        check("abort_ss", o.end_ss, 1);
        check("abort_sclk", o.end_sclk, 0);
        check("abort_rx", o.end_rx, 4'h0);
        run_frame(4'h3, -1, -1, o);
        check("after_abort_rx", o.rx_done, 4'h3);
        check("after_abort_done_at", o.done_at, 41);

        // Back-to-back with start held high.
        @(posedge clk); #1; bus.start = 1'b1; bus.tx_data = 4'h9;
        @(posedge clk); #1; bus.tx_data = 4'h6;
        k = 1; dones = 0; gap = 0;
        rxs[0] = '0; rxs[1] = '0;
        while (dones < 2 && k < 3 * FRAME_BUDGET) begin
            @(negedge clk);
            if (bus.done) begin
                rxs[dones] = bus.rx_data;
                dones++;
            end
            if (dones == 1 && bus.ss_n_out) gap++;
            @(posedge clk); #1;
            k++;
        end
        bus.start = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_rx0", rxs[0], 4'h9);
        check("b2b_rx1", rxs[1], 4'h6);
        check("b2b_gap_ge4", gap >= 4, 1);
        repeat (50) @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) loop_en = 1'($urandom_range(0, 1));
            miso_drv = 1'($urandom_range(0, 1));
            bus.start = ($urandom_range(0, 3) == 0);
            bus.tx_data = 4'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("random_activity", m_dones > 20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
